// File: rtl/sccb_pkg.sv
// Shared constants, entry decoding helper and FSM state type for the SCCB power-up sequencer.
package sccb_pkg;

    localparam logic [31:0] SCCB_ADDR_DATA = 32'h0000_0000;
    localparam logic [31:0] SCCB_ADDR_BUSY = 32'h0000_0004;
    localparam logic [3:0]  SCCB_BE_16     = 4'b0011;
    localparam logic [3:0]  SCCB_BE_NONE   = 4'b0000;
    localparam logic [15:0] ENTRY_END      = 16'hFFFF;
    localparam logic [7:0]  ENTRY_WAIT_HI  = 8'hF0;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PWRUP  = 4'd1,
        ST_FETCH  = 4'd2,
        ST_DECODE = 4'd3,
        ST_WRITE  = 4'd4,
        ST_SETTLE = 4'd5,
        ST_POLL   = 4'd6,
        ST_WAIT   = 4'd7,
        ST_DONE   = 4'd8,
        ST_ERR    = 4'd9
    } seq_state_e;

    // F0nn entries are delays of nn milliseconds rather than register writes
    function automatic logic is_wait_entry(input logic [15:0] entry);
        return (entry[15:8] == ENTRY_WAIT_HI);
    endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Register table for the power-up sequence: one 16-bit {reg_addr, reg_data} word per entry,
// entry 0 in the least significant 16 bits of ROM_INIT, read with one cycle of latency.
module sccb_init_rom #(
    parameter int                            ROM_AW   = 8,
    parameter logic [(2**ROM_AW)*16-1:0]     ROM_INIT = '1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ROM_AW-1:0] addr,
    output logic [15:0]       data
);

    // Registered table read
    always_ff @(posedge CLK) begin
        if (RST) begin
            data <= 16'h0000;
        end else begin
            data <= ROM_INIT[{addr, 4'h0} +: 16];
        end
    end

endmodule

// File: rtl/sccb_init_seq.sv
// Camera power-up sequencer: waits for supply settle, then walks the register table writing
// each entry to the SCCB controller and polling its busy flag; reports DONE or ERR.
module sccb_init_seq
    import sccb_pkg::*;
#(
    parameter int                            CLK_FREQ_HZ = 50_000_000,
    parameter int                            PWRUP_MS    = 10,
    parameter int                            ROM_AW      = 8,
    parameter int                            POLL_TMO    = 2_000_000,
    parameter logic [(2**ROM_AW)*16-1:0]     ROM_INIT    = '1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic [31:0]       IO_Address,
    output logic [31:0]       IO_Write_Data,
    output logic [3:0]        IO_Byte_Enable,
    output logic              WR,
    input  logic [31:0]       RDATA,
    output logic              SEQ_BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ROM_AW-1:0] ENTRY_IDX
);

    localparam int TICK_CYC = (CLK_FREQ_HZ / 1000 > 0) ? (CLK_FREQ_HZ / 1000) : 1;
    localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int POLL_W   = (POLL_TMO > 1) ? $clog2(POLL_TMO + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TMO - 1);
    localparam logic [POLL_W-1:0] POLL_ONE  = POLL_W'(1);
    localparam logic [ROM_AW-1:0] IDX_LAST  = '1;
    localparam logic [ROM_AW-1:0] IDX_ONE   = ROM_AW'(1);
    localparam logic [15:0]       PWRUP_TGT = 16'(PWRUP_MS);

    seq_state_e        state_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [15:0]       ms_cnt_r;
    logic [15:0]       ms_tgt_r;
    logic [POLL_W-1:0] poll_cnt_r;
    logic [15:0]       rom_data_s;
    logic              tick_wrap_s;
    logic              ms_done_s;
    logic              last_entry_s;
    logic              unused_rdata_s;

    sccb_init_rom #(
        .ROM_AW   (ROM_AW),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .CLK  (CLK),
        .RST  (RST),
        .addr (ENTRY_IDX),
        .data (rom_data_s)
    );

    // Delay-complete and end-of-table conditions shared by PWRUP, WAIT, DECODE and POLL
    always_comb begin
        tick_wrap_s    = (tick_cnt_r == TICK_LAST);
        ms_done_s      = (ms_tgt_r == 16'h0000) ||
                         (tick_wrap_s && (ms_cnt_r == (ms_tgt_r - 16'h0001)));
        last_entry_s   = (ENTRY_IDX == IDX_LAST);
        unused_rdata_s = ^RDATA[31:1];
    end

    // Sequencer FSM with all bus outputs registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= ST_PWRUP;
            WR             <= 1'b0;
            IO_Byte_Enable <= SCCB_BE_NONE;
            IO_Address     <= SCCB_ADDR_DATA;
            IO_Write_Data  <= 32'h0000_0000;
            DONE           <= 1'b0;
            ERR            <= 1'b0;
            SEQ_BUSY       <= 1'b1;
            ENTRY_IDX      <= '0;
            tick_cnt_r     <= '0;
            ms_cnt_r       <= 16'h0000;
            ms_tgt_r       <= PWRUP_TGT;
            poll_cnt_r     <= '0;
        end else begin
            case (state_r)
                ST_PWRUP: begin
                    if (ms_done_s) begin
                        state_r <= ST_FETCH;
                    end else if (tick_wrap_s) begin
                        tick_cnt_r <= '0;
                        ms_cnt_r   <= ms_cnt_r + 16'h0001;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    end
                end

                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end

                ST_DECODE: begin
                    if (rom_data_s == ENTRY_END) begin
                        DONE     <= 1'b1;
                        SEQ_BUSY <= 1'b0;
                        state_r  <= ST_DONE;
                    end else if (is_wait_entry(rom_data_s)) begin
                        // A zero-length delay just moves on to the next entry
                        if (rom_data_s[7:0] == 8'h00) begin
                            if (last_entry_s) begin
                                DONE     <= 1'b1;
                                SEQ_BUSY <= 1'b0;
                                state_r  <= ST_DONE;
                            end else begin
                                ENTRY_IDX <= ENTRY_IDX + IDX_ONE;
                                state_r   <= ST_FETCH;
                            end
                        end else begin
                            ms_tgt_r   <= {8'h00, rom_data_s[7:0]};
                            ms_cnt_r   <= 16'h0000;
                            tick_cnt_r <= '0;
                            state_r    <= ST_WAIT;
                        end
                    end else begin
                        WR             <= 1'b1;
                        IO_Address     <= SCCB_ADDR_DATA;
                        IO_Byte_Enable <= SCCB_BE_16;
                        IO_Write_Data  <= {16'h0000, rom_data_s};
                        state_r        <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    WR             <= 1'b0;
                    IO_Byte_Enable <= SCCB_BE_NONE;
                    IO_Address     <= SCCB_ADDR_BUSY;
                    state_r        <= ST_SETTLE;
                end

                // The controller raises busy one cycle after the strobe, so skip one read
                ST_SETTLE: begin
                    poll_cnt_r <= '0;
                    state_r    <= ST_POLL;
                end

                ST_POLL: begin
                    if (!RDATA[0]) begin
                        IO_Address <= SCCB_ADDR_DATA;
                        if (last_entry_s) begin
                            DONE     <= 1'b1;
                            SEQ_BUSY <= 1'b0;
                            state_r  <= ST_DONE;
                        end else begin
                            ENTRY_IDX <= ENTRY_IDX + IDX_ONE;
                            state_r   <= ST_FETCH;
                        end
                    end else if (poll_cnt_r == POLL_LAST) begin
                        IO_Address <= SCCB_ADDR_DATA;
                        ERR        <= 1'b1;
                        SEQ_BUSY   <= 1'b0;
                        state_r    <= ST_ERR;
                    end else begin
                        poll_cnt_r <= poll_cnt_r + POLL_ONE;
                    end
                end

                ST_WAIT: begin
                    if (ms_done_s) begin
                        if (last_entry_s) begin
                            DONE     <= 1'b1;
                            SEQ_BUSY <= 1'b0;
                            state_r  <= ST_DONE;
                        end else begin
                            ENTRY_IDX <= ENTRY_IDX + IDX_ONE;
                            state_r   <= ST_FETCH;
                        end
                    end else if (tick_wrap_s) begin
                        tick_cnt_r <= '0;
                        ms_cnt_r   <= ms_cnt_r + 16'h0001;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    end
                end

                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (START) begin
                        DONE       <= 1'b0;
                        ERR        <= 1'b0;
                        SEQ_BUSY   <= 1'b1;
                        ENTRY_IDX  <= '0;
                        tick_cnt_r <= '0;
                        ms_cnt_r   <= 16'h0000;
                        ms_tgt_r   <= PWRUP_TGT;
                        state_r    <= ST_PWRUP;
                    end else begin
                        state_r <= state_r;
                    end
                end

                // An illegal state encoding parks the sequencer in ERR with the bus quiet
                default: begin
                    WR             <= 1'b0;
                    IO_Byte_Enable <= SCCB_BE_NONE;
                    IO_Address     <= SCCB_ADDR_DATA;
                    ERR            <= 1'b1;
                    SEQ_BUSY       <= 1'b0;
                    state_r        <= ST_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench: main table with a busy-model controller, a stuck-busy timeout instance and a
// small table that runs off its last index without an end marker.
module tb_sccb_init_seq;

    localparam int BUSY_LEN = 50;
    localparam logic [256*16-1:0] TBL_A =
        {{251{16'hFFFF}}, 16'hFFFF, 16'h1101, 16'hF003, 16'h1180, 16'h1280};
    localparam logic [256*16-1:0] TBL_T = {{255{16'hFFFF}}, 16'h1234};
    localparam logic [4*16-1:0]   TBL_W = {16'h1004, 16'hF000, 16'h1002, 16'h1001};

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        a_wr, a_busy, a_done, a_err;
    logic [7:0]  a_idx;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_be;
    logic        t_wr, t_busy, t_done, t_err;
    logic [7:0]  t_idx;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_be;
    logic        w_wr, w_busy, w_done, w_err;
    logic [1:0]  w_idx;
    int          busy_cnt, t_wr_cnt, w_wr_cnt;

    sccb_init_seq #(.CLK_FREQ_HZ(4000), .PWRUP_MS(2), .ROM_AW(8), .POLL_TMO(1000), .ROM_INIT(TBL_A)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .IO_Address(a_addr), .IO_Write_Data(a_wdata),
        .IO_Byte_Enable(a_be), .WR(a_wr), .RDATA(a_rdata), .SEQ_BUSY(a_busy), .DONE(a_done),
        .ERR(a_err), .ENTRY_IDX(a_idx));

    sccb_init_seq #(.CLK_FREQ_HZ(4000), .PWRUP_MS(2), .ROM_AW(8), .POLL_TMO(20), .ROM_INIT(TBL_T)) u_tmo (
        .CLK(clk), .RST(rst), .START(start), .IO_Address(t_addr), .IO_Write_Data(t_wdata),
        .IO_Byte_Enable(t_be), .WR(t_wr), .RDATA(32'h0000_0001), .SEQ_BUSY(t_busy), .DONE(t_done),
        .ERR(t_err), .ENTRY_IDX(t_idx));

    sccb_init_seq #(.CLK_FREQ_HZ(4000), .PWRUP_MS(2), .ROM_AW(2), .POLL_TMO(1000), .ROM_INIT(TBL_W)) u_wrap (
        .CLK(clk), .RST(rst), .START(start), .IO_Address(w_addr), .IO_Write_Data(w_wdata),
        .IO_Byte_Enable(w_be), .WR(w_wr), .RDATA(32'h0000_0000), .SEQ_BUSY(w_busy), .DONE(w_done),
        .ERR(w_err), .ENTRY_IDX(w_idx));

    // Behavioural controller: busy rises the cycle after a write strobe and lasts BUSY_LEN cycles
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (a_wr) begin
            busy_cnt <= BUSY_LEN;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign a_rdata = {31'b0, (busy_cnt != 0)};

    // Write-strobe counters for the auxiliary instances
    always @(posedge clk) begin
        if (rst) begin
            t_wr_cnt <= 0;
            w_wr_cnt <= 0;
        end else begin
            if (t_wr) t_wr_cnt <= t_wr_cnt + 1;
            if (w_wr) w_wr_cnt <= w_wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step negedges until the selected main-instance output goes high, bounded by max_cyc
    task automatic wait_sig(input int which, input int max_cyc, output int n);
        logic hit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? a_wr : a_done;
        end while (!hit && n < max_cyc);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr", {31'b0, a_wr}, 32'h0);
        chk("rst_be", {28'b0, a_be}, 32'h0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_wdata", a_wdata, 32'h0);
        chk("rst_done", {31'b0, a_done}, 32'h0);
        chk("rst_err", {31'b0, a_err}, 32'h0);
        chk("rst_idx", {24'b0, a_idx}, 32'h0);
        chk("rst_seq_busy", {31'b0, a_busy}, 32'h1);

        rst = 1'b0;
        wait_sig(0, 40, n);
        chk("first_wr_latency", n, 10);
        chk("wr1_data", a_wdata, 32'h0000_1280);
        chk("wr1_be", {28'b0, a_be}, 32'h3);
        chk("wr1_addr", a_addr, 32'h0);
        chk("tmo_wr_data", t_wdata, 32'h0000_1234);
        chk("tmo_wr", {31'b0, t_wr}, 32'h1);

        @(negedge clk);
        chk("settle_addr", a_addr, 32'h4);
        chk("settle_wr", {31'b0, a_wr}, 32'h0);
        chk("settle_be", {28'b0, a_be}, 32'h0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("poll_addr", a_addr, 32'h4);
        chk("poll_seq_busy", {31'b0, a_busy}, 32'h1);
        chk("tmo_err_early", {31'b0, t_err}, 32'h0);
        @(negedge clk);
        chk("tmo_err", {31'b0, t_err}, 32'h1);
        chk("tmo_seq_busy", {31'b0, t_busy}, 32'h0);
        chk("tmo_addr", t_addr, 32'h0);

        wait_sig(0, 100, n);
        chk("gap_wr1_wr2", n, 32);
        chk("wr2_data", a_wdata, 32'h0000_1180);
        wait_sig(0, 120, n);
        chk("gap_wr2_wr3_wait", n, 68);
        chk("wr3_data", a_wdata, 32'h0000_1101);
        chk("wr3_idx", {24'b0, a_idx}, 32'd3);
        wait_sig(1, 100, n);
        chk("done_latency", n, 54);
        chk("done_seq_busy", {31'b0, a_busy}, 32'h0);
        chk("done_idx", {24'b0, a_idx}, 32'd4);
        chk("done_err", {31'b0, a_err}, 32'h0);
        chk("tmo_wr_count", t_wr_cnt, 32'd1);
        chk("wrap_done", {31'b0, w_done}, 32'h1);
        chk("wrap_wr_count", w_wr_cnt, 32'd3);
        chk("wrap_idx", {30'b0, w_idx}, 32'd3);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", {31'b0, a_done}, 32'h0);
        chk("restart_seq_busy", {31'b0, a_busy}, 32'h1);
        chk("restart_idx", {24'b0, a_idx}, 32'h0);
        chk("restart_tmo_err", {31'b0, t_err}, 32'h0);
        wait_sig(0, 40, n);
        chk("restart_wr_latency", n, 10);
        chk("restart_wr1_data", a_wdata, 32'h0000_1280);
        wait_sig(0, 100, n);
        chk("restart_gap", n, 54);
        chk("restart_wr2_data", a_wdata, 32'h0000_1180);
        chk("restart_wr2_idx", {24'b0, a_idx}, 32'd1);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr", {31'b0, a_wr}, 32'h0);
        chk("midrst_done", {31'b0, a_done}, 32'h0);
        chk("midrst_idx", {24'b0, a_idx}, 32'h0);
        chk("midrst_addr", a_addr, 32'h0);
        chk("midrst_seq_busy", {31'b0, a_busy}, 32'h1);
        rst = 1'b0;
        wait_sig(0, 40, n);
        chk("midrst_wr_latency", n, 10);
        chk("midrst_wr_data", a_wdata, 32'h0000_1280);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
